// File: rtl/instr_issue_seq.sv
// Program sequencer: fetches 16-bit instructions from synchronous program memory,
// launches each one on the control unit with an active-low run strobe and waits for done.
module instr_issue_seq #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [15:0]       instr,
  output logic              run,
  input  logic              done,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        instr_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    ISSUE = 3'd3,
    EXEC  = 3'd4
  } state_t;

  localparam logic [7:0] TMO_LIMIT = TIMEOUT[7:0];
  localparam logic [2:0] HALT_OP   = 3'b111;

  state_t            state_reg, state_next;
  logic              mem_rd_reg, mem_rd_next;
  logic [15:0]       instr_reg, instr_next;
  logic              run_reg, run_next;
  logic              halted_reg, halted_next;
  logic              error_reg, error_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [7:0]        count_reg, count_next;
  logic [7:0]        tmo_reg, tmo_next;

  logic halt_op;
  logic tmo_hit;

  assign halt_op = (mem_data[15:13] == HALT_OP);
  assign tmo_hit = ((tmo_reg + 8'd1) == TMO_LIMIT);

  always_comb begin
    state_next  = state_reg;
    instr_next  = instr_reg;
    halted_next = halted_reg;
    error_next  = error_reg;
    pc_next     = pc_reg;
    count_next  = count_reg;
    tmo_next    = tmo_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          pc_next     = start_addr;
          halted_next = 1'b0;
          error_next  = 1'b0;
          count_next  = 8'd0;
          // a stop already pending when FETCH would be entered cancels the read
          state_next  = stop ? IDLE : FETCH;
        end
      end

      FETCH: begin
        state_next = LATCH;
      end

      LATCH: begin
        if (halt_op) begin
          halted_next = 1'b1;
          state_next  = IDLE;
        end else begin
          instr_next  = mem_data;
          state_next  = ISSUE;
        end
      end

      ISSUE: begin
        tmo_next   = 8'd0;
        state_next = EXEC;
      end

      EXEC: begin
        if (done) begin
          pc_next    = pc_reg + ADDR_W'(1);
          count_next = (count_reg == 8'hFF) ? count_reg : count_reg + 8'd1;
          state_next = stop ? IDLE : FETCH;
        end else if (tmo_hit) begin
          error_next = 1'b1;
          tmo_next   = tmo_reg + 8'd1;
          state_next = IDLE;
        end else begin
          tmo_next   = tmo_reg + 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // strobes are registered, so they are derived from the state being entered
    mem_rd_next = (state_next == FETCH);
    run_next    = (state_next != ISSUE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      mem_rd_reg <= 1'b0;
      instr_reg  <= 16'h0000;
      run_reg    <= 1'b1;
      halted_reg <= 1'b0;
      error_reg  <= 1'b0;
      pc_reg     <= '0;
      count_reg  <= 8'd0;
      tmo_reg    <= 8'd0;
    end else begin
      state_reg  <= state_next;
      mem_rd_reg <= mem_rd_next;
      instr_reg  <= instr_next;
      run_reg    <= run_next;
      halted_reg <= halted_next;
      error_reg  <= error_next;
      pc_reg     <= pc_next;
      count_reg  <= count_next;
      tmo_reg    <= tmo_next;
    end
  end

  assign mem_rd      = mem_rd_reg;
  assign mem_addr    = pc_reg;
  assign instr       = instr_reg;
  assign run         = run_reg;
  assign busy        = (state_reg != IDLE);
  assign halted      = halted_reg;
  assign error       = error_reg;
  assign pc          = pc_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_instr_issue_seq.sv
// Scoreboard bench for instr_issue_seq: expected fetch addresses and issued
// instructions are queued at stimulus time and popped when mem_rd / run low appear.
module tb_instr_issue_seq;

  localparam int ADDR_W  = 5;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data = 16'h0000;
  logic [15:0]       instr;
  logic              run;
  logic              done;
  logic              busy;
  logic              halted;
  logic              error;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        instr_count;

  logic [15:0] mem [0:(1<<ADDR_W)-1];

  int checks = 0;
  int failures = 0;

  logic [15:0]       exp_instr_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];

  int   run_pulses = 0;
  int   rd_count = 0;
  int   exec_cycles = 0;
  logic run_prev = 1'b1;

  int   done_lat = 1;
  bit   done_en = 1'b0;
  int   dcnt = 0;
  logic done_model = 1'b0;
  logic done_inj = 1'b0;

  assign done = done_model | done_inj;

  instr_issue_seq #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .stop       (stop),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .instr      (instr),
    .run        (run),
    .done       (done),
    .busy       (busy),
    .halted     (halted),
    .error      (error),
    .pc         (pc),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // synchronous program memory: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // monitor + control-unit model, all on the falling edge
  always @(negedge clk) begin
    if (mem_rd) begin
      rd_count++;
      check_eq("rd_expected", 32'(exp_addr_q.size() > 0), 1);
      if (exp_addr_q.size() > 0) check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
    end
    if (!run) begin
      run_pulses++;
      exec_cycles = 0;
      check_eq("run_single_cycle", 32'(run_prev), 1);
      check_eq("run_expected", 32'(exp_instr_q.size() > 0), 1);
      if (exp_instr_q.size() > 0) check_eq("instr_at_run", 32'(instr), 32'(exp_instr_q.pop_front()));
    end else if (busy) begin
      exec_cycles++;
    end
    run_prev = run;

    done_model = 1'b0;
    if (!done_en) dcnt = 0;
    else if (!run) dcnt = done_lat;
    else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) done_model = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] a);
    @(negedge clk);
    start_addr = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_idle_in_time"}, 32'(busy), 0);
  endtask

  task automatic wait_run_low(input string tag);
    int n = 0;
    while (run && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_run_low_in_time"}, 32'(run), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'h0000;

    // reset values
    tick(3);
    check_eq("rst_run", 32'(run), 1);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_mem_rd", 32'(mem_rd), 0);
    check_eq("rst_instr", 32'(instr), 0);
    check_eq("rst_halted", 32'(halted), 0);
    check_eq("rst_error", 32'(error), 0);
    check_eq("rst_pc", 32'(pc), 0);
    check_eq("rst_count", 32'(instr_count), 0);
    reset_n = 1'b1;
    tick(2);

    // single MV then HALT, done two cycles after run low
    mem[0] = 16'h0A05; mem[1] = 16'hE000;
    exp_instr_q.push_back(16'h0A05);
    exp_addr_q.push_back(5'd0); exp_addr_q.push_back(5'd1);
    done_en = 1'b1; done_lat = 2; run_pulses = 0;
    do_start(5'd0);
    wait_idle("t1");
    check_eq("t1_halted", 32'(halted), 1);
    check_eq("t1_pc", 32'(pc), 1);
    check_eq("t1_count", 32'(instr_count), 1);
    check_eq("t1_instr", 32'(instr), 32'h0A05);
    check_eq("t1_error", 32'(error), 0);
    check_eq("t1_pulses", 32'(run_pulses), 1);

    // three instructions at address 4, done latency 3
    mem[4] = 16'h2123; mem[5] = 16'h4456; mem[6] = 16'h0A07; mem[7] = 16'hE000;
    exp_instr_q.push_back(16'h2123); exp_instr_q.push_back(16'h4456); exp_instr_q.push_back(16'h0A07);
    for (int a = 4; a <= 7; a++) exp_addr_q.push_back(5'(a));
    done_lat = 3; run_pulses = 0;
    do_start(5'd4);
    wait_idle("t2");
    check_eq("t2_pc", 32'(pc), 7);
    check_eq("t2_count", 32'(instr_count), 3);
    check_eq("t2_pulses", 32'(run_pulses), 3);
    check_eq("t2_halted", 32'(halted), 1);
    check_eq("t2_instr", 32'(instr), 32'h0A07);

    // done never arrives: timeout after TIMEOUT EXEC cycles
    mem[10] = 16'h1234;
    exp_instr_q.push_back(16'h1234);
    exp_addr_q.push_back(5'd10);
    done_en = 1'b0;
    do_start(5'd10);
    wait_idle("t3");
    check_eq("t3_error", 32'(error), 1);
    check_eq("t3_busy", 32'(busy), 0);
    check_eq("t3_pc", 32'(pc), 10);
    check_eq("t3_count", 32'(instr_count), 0);
    check_eq("t3_halted", 32'(halted), 0);
    check_eq("t3_exec_cycles", 32'(exec_cycles), TIMEOUT);

    // an accepted start clears error
    exp_instr_q.push_back(16'h0A05);
    exp_addr_q.push_back(5'd0); exp_addr_q.push_back(5'd1);
    done_en = 1'b1; done_lat = 1;
    do_start(5'd0);
    check_eq("t3b_error_cleared", 32'(error), 0);
    wait_idle("t3b");
    check_eq("t3b_halted", 32'(halted), 1);
    check_eq("t3b_count", 32'(instr_count), 1);

    // PC wraps from 31 to 0
    mem[31] = 16'h0C01; mem[0] = 16'hE000;
    exp_instr_q.push_back(16'h0C01);
    exp_addr_q.push_back(5'd31); exp_addr_q.push_back(5'd0);
    do_start(5'd31);
    wait_idle("t4");
    check_eq("t4_pc_wrap", 32'(pc), 0);
    check_eq("t4_halted", 32'(halted), 1);
    check_eq("t4_count", 32'(instr_count), 1);

    // done during ISSUE and start during EXEC are ignored
    mem[12] = 16'h2222; mem[13] = 16'hE000;
    exp_instr_q.push_back(16'h2222);
    exp_addr_q.push_back(5'd12); exp_addr_q.push_back(5'd13);
    done_en = 1'b0;
    do_start(5'd12);
    wait_run_low("t5");
    done_inj = 1'b1;
    @(negedge clk);
    done_inj = 1'b0;
    start_addr = 5'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tick(4);
    check_eq("t5_still_busy", 32'(busy), 1);
    check_eq("t5_pc_held", 32'(pc), 12);
    check_eq("t5_run_high", 32'(run), 1);
    check_eq("t5_count", 32'(instr_count), 0);
    done_inj = 1'b1;
    @(negedge clk);
    done_inj = 1'b0;
    wait_idle("t5");
    check_eq("t5_pc", 32'(pc), 13);
    check_eq("t5_halted", 32'(halted), 1);
    check_eq("t5_count_end", 32'(instr_count), 1);

    // asynchronous reset while in EXEC
    mem[16] = 16'h3333;
    exp_instr_q.push_back(16'h3333);
    exp_addr_q.push_back(5'd16);
    do_start(5'd16);
    wait_run_low("t6");
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_rst_run", 32'(run), 1);
    check_eq("t6_rst_busy", 32'(busy), 0);
    check_eq("t6_rst_pc", 32'(pc), 0);
    check_eq("t6_rst_instr", 32'(instr), 0);
    check_eq("t6_rst_mem_rd", 32'(mem_rd), 0);
    check_eq("t6_rst_count", 32'(instr_count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(2);

    // stop during EXEC finishes the instruction, then no further fetch
    mem[16] = 16'h3333; mem[17] = 16'h3344; mem[18] = 16'hE000;
    exp_instr_q.push_back(16'h3333);
    exp_addr_q.push_back(5'd16);
    done_en = 1'b1; done_lat = 2; rd_count = 0;
    do_start(5'd16);
    wait_run_low("t7");
    @(negedge clk);
    stop = 1'b1;
    wait_idle("t7");
    stop = 1'b0;
    tick(3);
    check_eq("t7_pc", 32'(pc), 17);
    check_eq("t7_count", 32'(instr_count), 1);
    check_eq("t7_halted", 32'(halted), 0);
    check_eq("t7_error", 32'(error), 0);
    check_eq("t7_rd_count", 32'(rd_count), 1);
    check_eq("instr_q_drained", 32'(exp_instr_q.size()), 0);
    check_eq("addr_q_drained", 32'(exp_addr_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_issue_seq.md
Name: instr_issue_seq

Overview:
- Program sequencer that drives the processor control unit from the instruction side.
- Fetches 16-bit instructions from a synchronous program memory and presents each one on `instr`.
- Launches the instruction by asserting `run` low for one cycle, then waits for `done` and advances the PC.
- Stops on a HALT opcode, on a `stop` request, or on a `done` timeout.

Parameters:
- ADDR_W, 5, program memory address width; PC wraps modulo 2^ADDR_W.
- TIMEOUT, 15, maximum EXEC cycles without `done` before the sequencer flags an error; legal range 4..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  pulse; begins execution at start_addr. Sampled only in IDLE.
- start_addr  input  ADDR_W  first instruction address.
- stop  input  1  level; finish the current instruction, then return to IDLE.
- mem_rd  output  1  program memory read strobe.
- mem_addr  output  ADDR_W  program memory address (equals pc).
- mem_data  input  16  read data, valid the cycle after mem_rd.
- instr  output  16  instruction presented to the control unit IR input.
- run  output  1  active-low launch strobe to the control unit; idles high.
- done  input  1  active-high completion from the control unit.
- busy  output  1  high in every state except IDLE.
- halted  output  1  sticky; set by HALT, cleared by an accepted start.
- error  output  1  sticky; set by timeout, cleared by an accepted start.
- pc  output  ADDR_W  current program counter.
- instr_count  output  8  instructions completed since the last accepted start; saturates at 255.

Behaviour:
- Reset values (asynchronous): state=IDLE, mem_rd=0, instr=0, run=1, busy=0, halted=0, error=0, pc=0, instr_count=0, timeout counter=0.
- States: IDLE, FETCH, LATCH, ISSUE, EXEC.
- IDLE:
  - start=1 → pc<=start_addr, halted<=0, error<=0, instr_count<=0, next FETCH.
- FETCH:
  - mem_rd=1 and mem_addr=pc for exactly one cycle, next LATCH.
  - If stop=1 on entry to FETCH, go to IDLE instead; no read is issued.
- LATCH:
  - mem_data is valid. If mem_data[15:13]==3'b111 (HALT): halted<=1, instr unchanged, next IDLE, run stays high.
  - Otherwise instr<=mem_data, next ISSUE.
- ISSUE:
  - run=0 for exactly this one cycle, timeout counter<=0, next EXEC.
- EXEC:
  - run=1. instr is held stable for the whole instruction.
  - done=1 → pc<=pc+1 (wraps to 0 after 2^ADDR_W-1), instr_count<=instr_count+1 (saturating).
    - stop=1 in the same cycle → next IDLE; otherwise next FETCH.
  - done=0 → counter increments. When the counter reaches TIMEOUT → error<=1, next IDLE, pc unchanged.
- Minimum instruction period with done arriving one cycle after ISSUE is 4 cycles: FETCH, LATCH, ISSUE, EXEC.
- done outside EXEC is ignored, including during ISSUE.
- start outside IDLE is ignored.
- stop sampled in FETCH or EXEC only; an in-flight instruction always completes or times out.
- Reset mid-operation returns all outputs to reset values immediately; run returns high asynchronously.
- busy is combinational from state.
- All other outputs are registered.

Test Plan:
- Mem[0]=16'h0A05 (MV), mem[1]=16'hE000; start_addr=0, start; done 2 cycles after run low → instr=16'h0A05, one run-low pulse, then halted=1, pc=1, instr_count=1, busy=0.
- Three-instruction program at addr 4 (ADD, SUB, MV) followed by HALT, done latency 3 → three single-cycle run pulses, each preceded by mem_rd with mem_addr 4, 5, 6; final pc=7, instr_count=3.
- done never asserted, TIMEOUT=15 → after 15 EXEC cycles error=1, busy=0, pc unchanged. A following start clears error.
- start_addr=31 (ADDR_W=5), mem[31] non-HALT, mem[0]=HALT → pc wraps to 0 and halted=1.
- start pulsed during EXEC and done pulsed during ISSUE → both ignored. Sequencer stays in EXEC until a later done.
- reset_n low while in EXEC with run high, then stop=1 set during a later EXEC → reset yields all reset values. stop completes the current instruction, returns to IDLE with no further mem_rd, halted=0.
